// File: rtl/microwave_power_ctrl.sv
// Microwave oven power controller: cook timer with a door interlock and a
// tick-based duty cycle that sets the magnetron's average power.
module microwave_power_ctrl #(
  parameter int unsigned TIME_W   = 12,
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned PWR_W    = 4,
  parameter int unsigned PWR_MAX  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              closed_door,
  input  logic              load,
  input  logic [TIME_W-1:0] time_in,
  input  logic [PWR_W-1:0]  power_in,
  output logic              magnetron,
  output logic [TIME_W-1:0] remaining,
  output logic [1:0]        state,
  output logic              done
);

  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0]   DivLast   = DivW'(TICK_DIV - 1);
  localparam logic [PWR_W-1:0]  PwrMax    = PWR_W'(PWR_MAX);
  localparam logic [PWR_W-1:0]  PhaseLast = PWR_W'(PWR_MAX - 1);
  localparam logic [TIME_W-1:0] TimeOne   = TIME_W'(1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCook   = 2'd1,
    StPaused = 2'd2,
    StDone   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TIME_W-1:0] rem_q, rem_d;
  logic [PWR_W-1:0]  pwr_q, pwr_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [PWR_W-1:0]  phase_q, phase_d;
  logic              start_q, stop_q, clear_q;
  logic              arm_q;
  logic              done_q, done_d;

  logic              start_e, stop_e, clear_e;
  logic [PWR_W-1:0]  pwr_clamped;

  // arm_q masks the first cycle after reset so a button held through the
  // release is captured as the previous value rather than seen as an edge.
  assign start_e = start & ~start_q & arm_q;
  assign stop_e  = stop  & ~stop_q  & arm_q;
  assign clear_e = clear & ~clear_q & arm_q;

  assign pwr_clamped = (power_in > PwrMax) ? PwrMax : power_in;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pwr_d   = pwr_q;
    div_d   = div_q;
    phase_d = phase_q;
    done_d  = 1'b0;

    if (clear_e) begin
      state_d = StIdle;
      rem_d   = '0;
      pwr_d   = PwrMax;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_e && closed_door && (rem_q != '0)) begin
            state_d = StCook;
            div_d   = '0;
            phase_d = '0;
          end else if (load) begin
            rem_d = time_in;
            pwr_d = pwr_clamped;
          end
        end
        StCook: begin
          if (stop_e || !closed_door) begin
            state_d = StPaused;
          end else if (div_q == DivLast) begin
            div_d   = '0;
            phase_d = (phase_q == PhaseLast) ? '0 : phase_q + PWR_W'(1);
            if (rem_q <= TimeOne) begin
              rem_d   = '0;
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              rem_d = rem_q - TimeOne;
            end
          end else begin
            div_d = div_q + DivW'(1);
          end
        end
        StPaused: begin
          if (stop_e) begin
            state_d = StIdle;
            rem_d   = '0;
          end else if (start_e && closed_door && (rem_q != '0)) begin
            state_d = StCook;
            div_d   = '0;
            phase_d = '0;
          end
        end
        StDone: begin
          if (start_e || !closed_door) begin
            state_d = StIdle;
          end else if (load) begin
            state_d = StIdle;
            rem_d   = time_in;
            pwr_d   = pwr_clamped;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      pwr_q   <= PwrMax;
      div_q   <= '0;
      phase_q <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      clear_q <= 1'b0;
      arm_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pwr_q   <= pwr_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      start_q <= start;
      stop_q  <= stop;
      clear_q <= clear;
      arm_q   <= 1'b1;
      done_q  <= done_d;
    end
  end

  // Combinational so the interlock cuts power in the cycle the door opens.
  assign magnetron = (state_q == StCook) & closed_door & (phase_q < pwr_q);
  assign remaining = rem_q;
  assign state     = state_q;
  assign done      = done_q;

endmodule
